// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: tag allocation, writeback completion tracking,
// in-order dual retire through a registered-read payload RAM, and flush.
module rob_ctrl #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 4,
    parameter int DEPTH = 1 << ADDR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_req_0,
    input  logic             alloc_req_1,
    input  logic [WIDTH-1:0] alloc_data_0,
    input  logic [WIDTH-1:0] alloc_data_1,
    output logic             alloc_gnt_0,
    output logic             alloc_gnt_1,
    output logic [ADDR-1:0]  alloc_tag_0,
    output logic [ADDR-1:0]  alloc_tag_1,
    input  logic             wb_valid_0,
    input  logic             wb_valid_1,
    input  logic [ADDR-1:0]  wb_tag_0,
    input  logic [ADDR-1:0]  wb_tag_1,
    input  logic             flush,
    output logic             commit_valid_0,
    output logic             commit_valid_1,
    output logic [ADDR-1:0]  commit_tag_0,
    output logic [ADDR-1:0]  commit_tag_1,
    output logic [WIDTH-1:0] commit_data_0,
    output logic [WIDTH-1:0] commit_data_1,
    output logic [ADDR-1:0]  ram_addr_in_0,
    output logic [ADDR-1:0]  ram_addr_in_1,
    output logic [WIDTH-1:0] ram_data_in_0,
    output logic [WIDTH-1:0] ram_data_in_1,
    output logic             ram_wr_en_0,
    output logic             ram_wr_en_1,
    output logic [ADDR-1:0]  ram_addr_out_0,
    output logic [ADDR-1:0]  ram_addr_out_1,
    output logic             ram_o_en_0,
    output logic             ram_o_en_1,
    input  logic [WIDTH-1:0] ram_data_out_0,
    input  logic [WIDTH-1:0] ram_data_out_1,
    output logic [ADDR:0]    count,
    output logic             full,
    output logic             empty
);

    localparam logic [ADDR:0] CAP = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0] TWO = (ADDR+1)'(2);

    // Pointers carry a wrap bit so occupancy is simply tail - head.
    logic [ADDR:0]     head, tail;
    logic [DEPTH-1:0]  valid, done, valid_n, done_n;
    logic              rd_pend_0, rd_pend_1;
    logic [ADDR-1:0]   rd_tag_0, rd_tag_1;
    logic [ADDR-1:0]   h0, h1, t0, t1;
    logic [ADDR:0]     free;
    logic              kill, r0, r1;

    // Reset behaves like a flush, and additionally silences combinational outputs.
    assign kill  = flush | ~reset;
    assign count = tail - head;
    assign free  = CAP - count;
    assign full  = (count == CAP);
    assign empty = (count == '0);

    assign h0 = head[ADDR-1:0];
    assign h1 = h0 + ADDR'(1);
    assign t0 = tail[ADDR-1:0];
    assign t1 = t0 + ADDR'(1);

    assign alloc_gnt_0 = alloc_req_0 & (free != '0) & ~kill;
    assign alloc_gnt_1 = alloc_req_1 & alloc_gnt_0 & (free >= TWO);
    assign alloc_tag_0 = t0;
    assign alloc_tag_1 = t1;

    assign ram_wr_en_0   = alloc_gnt_0;
    assign ram_wr_en_1   = alloc_gnt_1;
    assign ram_addr_in_0 = t0;
    assign ram_addr_in_1 = t1;
    assign ram_data_in_0 = alloc_gnt_0 ? alloc_data_0 : '0;
    assign ram_data_in_1 = alloc_gnt_1 ? alloc_data_1 : '0;

    // Retire only from the registered done state, strictly in order from head.
    assign r0 = valid[h0] & done[h0] & ~kill;
    assign r1 = r0 & valid[h1] & done[h1];

    assign ram_o_en_0     = r0;
    assign ram_o_en_1     = r1;
    assign ram_addr_out_0 = h0;
    assign ram_addr_out_1 = h1;

    // A read still in flight when flush/reset arrives never reaches commit.
    assign commit_valid_0 = rd_pend_0 & ~kill;
    assign commit_valid_1 = rd_pend_1 & ~kill;
    assign commit_tag_0   = rd_tag_0;
    assign commit_tag_1   = rd_tag_1;
    assign commit_data_0  = commit_valid_0 ? ram_data_out_0 : '0;
    assign commit_data_1  = commit_valid_1 ? ram_data_out_1 : '0;

    // Next per-entry state: writeback, then retire clear, then allocation set.
    always_comb begin
        valid_n = valid;
        done_n  = done;
        if (wb_valid_0 && valid[wb_tag_0]) done_n[wb_tag_0] = 1'b1;
        if (wb_valid_1 && valid[wb_tag_1]) done_n[wb_tag_1] = 1'b1;
        if (r0) begin
            valid_n[h0] = 1'b0;
            done_n[h0]  = 1'b0;
        end
        if (r1) begin
            valid_n[h1] = 1'b0;
            done_n[h1]  = 1'b0;
        end
        if (alloc_gnt_0) begin
            valid_n[t0] = 1'b1;
            done_n[t0]  = 1'b0;
        end
        if (alloc_gnt_1) begin
            valid_n[t1] = 1'b1;
            done_n[t1]  = 1'b0;
        end
    end

    // Pointer, entry and read-issue state; flush and reset clear everything.
    always_ff @(posedge clk) begin
        if (kill) begin
            head      <= '0;
            tail      <= '0;
            valid     <= '0;
            done      <= '0;
            rd_pend_0 <= 1'b0;
            rd_pend_1 <= 1'b0;
            rd_tag_0  <= '0;
            rd_tag_1  <= '0;
        end else begin
            head      <= head + (ADDR+1)'(r0) + (ADDR+1)'(r1);
            tail      <= tail + (ADDR+1)'(alloc_gnt_0) + (ADDR+1)'(alloc_gnt_1);
            valid     <= valid_n;
            done      <= done_n;
            rd_pend_0 <= r0;
            rd_pend_1 <= r1;
            rd_tag_0  <= h0;
            rd_tag_1  <= h1;
        end
    end

endmodule

// File: tb/tb_rob_ctrl.sv
// Bench for rob_ctrl: queue-based ROB model, payload RAM model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_rob_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_req_0, alloc_req_1;
    logic [7:0] alloc_data_0, alloc_data_1;
    logic       alloc_gnt_0, alloc_gnt_1;
    logic [3:0] alloc_tag_0, alloc_tag_1;
    logic       wb_valid_0, wb_valid_1;
    logic [3:0] wb_tag_0, wb_tag_1;
    logic       flush;
    logic       commit_valid_0, commit_valid_1;
    logic [3:0] commit_tag_0, commit_tag_1;
    logic [7:0] commit_data_0, commit_data_1;
    logic [3:0] ram_addr_in_0, ram_addr_in_1;
    logic [7:0] ram_data_in_0, ram_data_in_1;
    logic       ram_wr_en_0, ram_wr_en_1;
    logic [3:0] ram_addr_out_0, ram_addr_out_1;
    logic       ram_o_en_0, ram_o_en_1;
    logic [7:0] ram_data_out_0, ram_data_out_1;
    logic [4:0] count;
    logic       full, empty;

    rob_ctrl #(.WIDTH(8), .ADDR(4)) dut (
        .clk(clk), .reset(reset),
        .alloc_req_0(alloc_req_0), .alloc_req_1(alloc_req_1),
        .alloc_data_0(alloc_data_0), .alloc_data_1(alloc_data_1),
        .alloc_gnt_0(alloc_gnt_0), .alloc_gnt_1(alloc_gnt_1),
        .alloc_tag_0(alloc_tag_0), .alloc_tag_1(alloc_tag_1),
        .wb_valid_0(wb_valid_0), .wb_valid_1(wb_valid_1),
        .wb_tag_0(wb_tag_0), .wb_tag_1(wb_tag_1),
        .flush(flush),
        .commit_valid_0(commit_valid_0), .commit_valid_1(commit_valid_1),
        .commit_tag_0(commit_tag_0), .commit_tag_1(commit_tag_1),
        .commit_data_0(commit_data_0), .commit_data_1(commit_data_1),
        .ram_addr_in_0(ram_addr_in_0), .ram_addr_in_1(ram_addr_in_1),
        .ram_data_in_0(ram_data_in_0), .ram_data_in_1(ram_data_in_1),
        .ram_wr_en_0(ram_wr_en_0), .ram_wr_en_1(ram_wr_en_1),
        .ram_addr_out_0(ram_addr_out_0), .ram_addr_out_1(ram_addr_out_1),
        .ram_o_en_0(ram_o_en_0), .ram_o_en_1(ram_o_en_1),
        .ram_data_out_0(ram_data_out_0), .ram_data_out_1(ram_data_out_1),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Payload RAM: registered reads return pre-write contents on a same-edge hit.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_o_en_0) ram_data_out_0 <= mem[ram_addr_out_0];
        if (ram_o_en_1) ram_data_out_1 <= mem[ram_addr_out_1];
        if (ram_wr_en_0) mem[ram_addr_in_0] <= ram_data_in_0;
        if (ram_wr_en_1) mem[ram_addr_in_1] <= ram_data_in_1;
    end

    // Model: program-order queue of live entries; q[i] holds tag (hd+i)%16.
    typedef struct { bit [7:0] data; bit done; } ent_t;
    ent_t q[$];
    int   hd;
    bit   pv0, pv1;
    int   ptag0, ptag1, pdata0, pdata1;
    bit   eg0, eg1, er0, er1, ekill;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(string nm, int act, int exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, vectors);
        end
    endtask

    // Compare every DUT output against the model for the current inputs.
    task automatic check_model();
        int sz, fr;
        sz    = q.size();
        fr    = 16 - sz;
        ekill = flush || !reset;
        eg0   = alloc_req_0 && fr >= 1 && !ekill;
        eg1   = alloc_req_1 && eg0 && fr >= 2;
        er0   = !ekill && sz >= 1 && q[0].done;
        er1   = er0 && sz >= 2 && q[1].done;
        chk("gnt0", alloc_gnt_0, eg0);
        chk("gnt1", alloc_gnt_1, eg1);
        chk("wr_en0", ram_wr_en_0, eg0);
        chk("wr_en1", ram_wr_en_1, eg1);
        if (eg0) begin
            chk("tag0", alloc_tag_0, (hd + sz) % 16);
            chk("wr_addr0", ram_addr_in_0, (hd + sz) % 16);
            chk("wr_data0", ram_data_in_0, alloc_data_0);
        end
        if (eg1) begin
            chk("tag1", alloc_tag_1, (hd + sz + 1) % 16);
            chk("wr_addr1", ram_addr_in_1, (hd + sz + 1) % 16);
            chk("wr_data1", ram_data_in_1, alloc_data_1);
        end
        chk("o_en0", ram_o_en_0, er0);
        chk("o_en1", ram_o_en_1, er1);
        if (er0) chk("rd_addr0", ram_addr_out_0, hd);
        if (er1) chk("rd_addr1", ram_addr_out_1, (hd + 1) % 16);
        chk("cv0", commit_valid_0, pv0 && !ekill);
        chk("cv1", commit_valid_1, pv1 && !ekill);
        if (pv0 && !ekill) begin
            chk("ctag0", commit_tag_0, ptag0);
            chk("cdata0", commit_data_0, pdata0);
        end
        if (pv1 && !ekill) begin
            chk("ctag1", commit_tag_1, ptag1);
            chk("cdata1", commit_data_1, pdata1);
        end
        chk("count", count, sz);
        chk("full", full, sz == 16);
        chk("empty", empty, sz == 0);
        vectors++;
    endtask

    task automatic update_model();
        int sz, off;
        sz = q.size();
        if (ekill) begin
            q.delete();
            hd  = 0;
            pv0 = 0;
            pv1 = 0;
            return;
        end
        if (wb_valid_0) begin
            off = (int'(wb_tag_0) - hd + 16) % 16;
            if (off < sz) q[off].done = 1;
        end
        if (wb_valid_1) begin
            off = (int'(wb_tag_1) - hd + 16) % 16;
            if (off < sz) q[off].done = 1;
        end
        pv0 = er0;
        pv1 = er1;
        ptag0 = hd;
        ptag1 = (hd + 1) % 16;
        if (er0) pdata0 = q[0].data;
        if (er1) pdata1 = q[1].data;
        if (er0) void'(q.pop_front());
        if (er1) void'(q.pop_front());
        hd = (hd + int'(er0) + int'(er1)) % 16;
        if (eg0) q.push_back('{data: alloc_data_0, done: 1'b0});
        if (eg1) q.push_back('{data: alloc_data_1, done: 1'b0});
    endtask

    task automatic drive(bit r0 = 0, bit r1 = 0, bit [7:0] d0 = 0, bit [7:0] d1 = 0,
                         bit w0 = 0, bit [3:0] t0 = 0, bit w1 = 0, bit [3:0] t1 = 0,
                         bit fl = 0, bit rs = 1);
        @(negedge clk);
        alloc_req_0 = r0; alloc_req_1 = r1;
        alloc_data_0 = d0; alloc_data_1 = d1;
        wb_valid_0 = w0; wb_tag_0 = t0;
        wb_valid_1 = w1; wb_tag_1 = t1;
        flush = fl; reset = rs;
        #1;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        update_model();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        bit r0, r1, w0, w1, fl, rs;
        bit [3:0] t0, t1;
        // Uncheckable power-up: hold reset two edges before the model starts.
        reset = 0; flush = 0;
        alloc_req_0 = 0; alloc_req_1 = 0; alloc_data_0 = 0; alloc_data_1 = 0;
        wb_valid_0 = 0; wb_valid_1 = 0; wb_tag_0 = 0; wb_tag_1 = 0;
        repeat (2) @(posedge clk);
        hd = 0; pv0 = 0; pv1 = 0;

        // Reset state.
        drive();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_cv0", commit_valid_0, 0);
        tick();

        // Fill two per cycle, tags 0..15 in order, then full rejects.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1, 1, 8'(2 * k + 8'h30), 8'(2 * k + 8'h31));
            chk("fill_tag0", alloc_tag_0, 2 * k);
            chk("fill_tag1", alloc_tag_1, 2 * k + 1);
            chk("fill_gnt1", alloc_gnt_1, 1);
            tick();
        end
        drive(1, 1);
        chk("full_lit", full, 1);
        chk("full_gnt0", alloc_gnt_0, 0);
        tick();

        // Wrap: retire 14, then reuse tags 0..5.
        for (int k = 0; k < 7; k++) begin
            drive(0, 0, 0, 0, 1, 4'(2 * k), 1, 4'(2 * k + 1));
            tick();
        end
        repeat (8) begin drive(); tick(); end
        drive();
        chk("wrap_count2", count, 2);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 8'(8'h50 + 2 * k), 8'(8'h51 + 2 * k));
            chk("wrap_tag0", alloc_tag_0, 2 * k);
            chk("wrap_tag1", alloc_tag_1, 2 * k + 1);
            tick();
        end
        drive();
        chk("wrap_count8", count, 8);
        tick();
        drive(0, 0, 0, 0, 1, 4'd14, 1, 4'd15); tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 1, 4'(2 * k), 1, 4'(2 * k + 1)); tick();
        end
        repeat (6) begin drive(); tick(); end

        // Out-of-order done: both commit together two cycles after the head's wb.
        do_reset();
        drive(1, 1, 8'hA0, 8'hA1); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 4'd1); tick();
        drive(0, 0, 0, 0, 1, 4'd0);
        chk("ooo_no_retire", ram_o_en_0, 0);
        tick();
        drive();
        chk("ooo_oen0", ram_o_en_0, 1);
        chk("ooo_oen1", ram_o_en_1, 1);
        chk("ooo_cv_early", commit_valid_0, 0);
        tick();
        drive();
        chk("ooo_cv0", commit_valid_0, 1);
        chk("ooo_cv1", commit_valid_1, 1);
        chk("ooo_ctag1", commit_tag_1, 1);
        chk("ooo_cdata0", commit_data_0, 8'hA0);
        chk("ooo_cdata1", commit_data_1, 8'hA1);
        tick();

        // Flush right after a retire issue kills the in-flight read.
        do_reset();
        drive(1, 1, 8'h11, 8'h22); tick();
        drive(0, 0, 0, 0, 1, 4'd0); tick();
        drive();
        chk("fl_oen0", ram_o_en_0, 1);
        tick();
        drive(1, 0, 8'h77, 0, 0, 0, 0, 0, 1);
        chk("fl_gnt0", alloc_gnt_0, 0);
        chk("fl_cv0", commit_valid_0, 0);
        tick();
        drive(1, 0, 8'h88);
        chk("fl_empty", empty, 1);
        chk("fl_cv0_after", commit_valid_0, 0);
        chk("fl_tag0", alloc_tag_0, 0);
        tick();

        // Alloc 2 + retire 2 at count 15: one grant, count becomes 14.
        do_reset();
        for (int k = 0; k < 7; k++) begin drive(1, 1, 8'(k), 8'(k + 100)); tick(); end
        drive(1, 0, 8'hEE); tick();
        drive(0, 0, 0, 0, 1, 4'd0, 1, 4'd1); tick();
        drive(1, 1, 8'h5A, 8'h5B);
        chk("c15_gnt0", alloc_gnt_0, 1);
        chk("c15_gnt1", alloc_gnt_1, 0);
        chk("c15_oen1", ram_o_en_1, 1);
        tick();
        drive();
        chk("c15_count", count, 14);
        tick();

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r0 = ($urandom_range(0, 99) < 55);
            r1 = r0 && ($urandom_range(0, 1) == 1);
            w0 = ($urandom_range(0, 99) < 70);
            w1 = ($urandom_range(0, 99) < 50);
            t0 = (q.size() > 0 && $urandom_range(0, 3) != 0)
                 ? 4'((hd + $urandom_range(0, q.size() - 1)) % 16) : 4'($urandom);
            t1 = (q.size() > 0 && $urandom_range(0, 3) != 0)
                 ? 4'((hd + $urandom_range(0, q.size() - 1)) % 16) : 4'($urandom);
            fl = ($urandom_range(0, 79) == 0);
            rs = ($urandom_range(0, 199) != 0);
            drive(r0, r1, 8'($urandom), 8'($urandom), w0, t0, w1, t1, fl, rs);
            tick();
        end
        drive(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
